// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring) engine with start/done handshake.
// Define MULDIV_DIV_EN to compile in the divider datapath, sign fix-up and div0 flag.
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             div0,
   output logic [WIDTH-1:0] zhigh,
   output logic [WIDTH-1:0] zlow
);

   // state  | meaning
   // S_IDLE | waiting for start; operands latched on accept
   // S_RUN  | one Booth or restoring-division iteration per cycle
   // S_FIX  | divide sign correction (no-op for multiply)
   // S_DONE | publish result, pulse done
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state, state_nx;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   acc;
   logic [WIDTH:0]   mcand;
   logic [WIDTH-1:0] q;
   logic             q_m1;
   logic             op_r;
   logic [WIDTH:0]   booth_sum;

`ifdef MULDIV_DIV_EN
   logic             a_neg, b_neg, b_zero;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH+1:0] div_trial;

   // Magnitudes are unsigned, so -2^(WIDTH-1) maps to 2^(WIDTH-1) without overflow.
   assign a_mag     = A[WIDTH-1] ? -A : A;
   assign b_mag     = B[WIDTH-1] ? -B : B;
   assign div_shift = {acc[WIDTH-1:0], q[WIDTH-1]};
   assign div_trial = {1'b0, div_shift} - {1'b0, mcand};
`endif

   always_ff @(posedge clk) begin
      if (clr) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = S_RUN;
         S_RUN:   if (cnt == '0) state_nx = S_FIX;
         S_FIX:   state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      booth_sum = acc;
      case ({q[0], q_m1})
         2'b01:   booth_sum = acc + mcand;
         2'b10:   booth_sum = acc - mcand;
         default: booth_sum = acc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         busy  <= 1'b0;
         done  <= 1'b0;
         div0  <= 1'b0;
         zhigh <= '0;
         zlow  <= '0;
         cnt   <= '0;
         acc   <= '0;
         mcand <= '0;
         q     <= '0;
         q_m1  <= 1'b0;
         op_r  <= 1'b0;
`ifdef MULDIV_DIV_EN
         a_neg  <= 1'b0;
         b_neg  <= 1'b0;
         b_zero <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  op_r <= op;
                  cnt  <= CW'(WIDTH - 1);
                  acc  <= '0;
                  q_m1 <= 1'b0;
                  q     <= A;
                  mcand <= {B[WIDTH-1], B};
`ifdef MULDIV_DIV_EN
                  a_neg  <= A[WIDTH-1];
                  b_neg  <= B[WIDTH-1];
                  b_zero <= (B == '0);
                  if (op) begin
                     q     <= a_mag;
                     mcand <= {1'b0, b_mag};
                  end
`endif
               end
            end
            S_RUN: begin
               if (cnt != '0) cnt <= cnt - 1'b1;
               if (!op_r) begin
                  q_m1 <= q[0];
                  q    <= {booth_sum[0], q[WIDTH-1:1]};
                  acc  <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
               end
`ifdef MULDIV_DIV_EN
               else if (div_trial[WIDTH+1]) begin
                  acc <= div_shift;
                  q   <= {q[WIDTH-2:0], 1'b0};
               end else begin
                  acc <= div_trial[WIDTH:0];
                  q   <= {q[WIDTH-2:0], 1'b1};
               end
`endif
            end
            S_FIX: begin
`ifdef MULDIV_DIV_EN
               // With B == 0 the remainder is |A|, so restoring the sign of A yields A itself.
               if (op_r) begin
                  if (b_zero)             q <= '1;
                  else if (a_neg ^ b_neg) q <= -q;
                  if (a_neg)              acc <= -acc;
               end
`endif
            end
            S_DONE: begin
               busy <= 1'b0;
               done <= 1'b1;
               if (!op_r) begin
                  zhigh <= acc[WIDTH-1:0];
                  zlow  <= q;
                  div0  <= 1'b0;
               end else begin
`ifdef MULDIV_DIV_EN
                  zhigh <= acc[WIDTH-1:0];
                  zlow  <= q;
                  div0  <= b_zero;
`else
                  zhigh <= '0;
                  zlow  <= '0;
                  div0  <= 1'b0;
`endif
               end
            end
            default: busy <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus random operations against an arithmetic model.
module tb_mul_div_unit;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         clr, start, op;
   logic [W-1:0] a, b;
   logic         busy, done, div0;
   logic [W-1:0] zhigh, zlow;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] exp_hi = '0;
   logic [W-1:0] exp_lo = '0;
   logic         exp_d0 = 1'b0;

   always #5 clk = ~clk;

   mul_div_unit #(.WIDTH(W)) dut (
      .clk(clk), .clr(clr), .start(start), .op(op), .A(a), .B(b),
      .busy(busy), .done(done), .div0(div0), .zhigh(zhigh), .zlow(zlow)
   );

   task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Returns {div0, zhigh, zlow} from plain signed arithmetic.
   function automatic logic [64:0] model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
      longint sx, sy, p, qq, rr;
      logic [63:0] pv;
      logic [W-1:0] qv, rv;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (!o) begin
         p  = sx * sy;
         pv = p;
         return {1'b0, pv};
      end
`ifdef MULDIV_DIV_EN
      if (y == '0) return {1'b1, x, {W{1'b1}}};
      qq = sx / sy;
      rr = sx % sy;
      qv = qq[W-1:0];
      rv = rr[W-1:0];
      return {1'b0, rv, qv};
`else
      qq = 0; rr = 0; qv = '0; rv = '0;
      return {1'b0, rv, qv};
`endif
   endfunction

   task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input int dup_at, input string tag);
      logic [64:0] m;
      int n;
      logic seen;
      m = model(o, x, y);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; a = $urandom; b = $urandom; op = 1'($urandom);
      chk({tag, " busy_after_accept"}, 65'(busy), 65'(1));
      n = 0;
      seen = 1'b0;
      while (!seen && n < 60) begin
         if (n + 1 == dup_at) start = 1'b1;
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         n++;
         if (done) seen = 1'b1;
         else begin
            chk({tag, " busy_hold"}, 65'(busy), 65'(1));
            chk({tag, " result_hold"}, {div0, zhigh, zlow}, {exp_d0, exp_hi, exp_lo});
         end
      end
      chk({tag, " latency"}, 65'(n), 65'(W + 2));
      chk({tag, " result"}, {div0, zhigh, zlow}, m);
      chk({tag, " busy_at_done"}, 65'(busy), 65'(0));
      {exp_d0, exp_hi, exp_lo} = m;
      @(posedge clk);
      @(negedge clk);
      chk({tag, " done_single"}, 65'(done), 65'(0));
      chk({tag, " result_stable"}, {div0, zhigh, zlow}, m);
   endtask

   task automatic idle_check(input int cycles, input string tag);
      int cnt = 0;
      repeat (cycles) begin
         @(posedge clk);
         @(negedge clk);
         if (done) cnt++;
      end
      chk(tag, 65'(cnt), 65'(0));
   endtask

   function automatic logic [W-1:0] pick(input int sel);
      case (sel)
         0: return '0;
         1: return 32'h0000_0001;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return W'($urandom_range(0, 255));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      clr = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {busy, done, div0, zhigh, zlow}, '0);
      clr = 1'b0;

      run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 0, "mul_7_m3");
      run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 0, "mul_min_min");
      run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mul_m1_m1");
      run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, "div_m7_2");
      run_op(1'b1, 32'd100, 32'd7, 0, "div_100_7");
      run_op(1'b1, 32'd5, 32'd0, 0, "div_5_0");
      run_op(1'b0, 32'd3, 32'd4, 0, "mul_after_div0");
      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_min_m1");
      run_op(1'b1, 32'hFFFF_FFF0, 32'd0, 0, "div_neg_0");

      run_op(1'b0, 32'd12345, 32'hFFFF_FF00, 5, "mul_dup_start");
      idle_check(40, "dup_no_extra_done");

      run_op(1'b0, 32'h1234, 32'd1, 0, "mul_pre_clr");
      @(negedge clk);
      start = 1'b1; op = 1'b0; a = 32'd99; b = 32'd77;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      clr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("clr_mid_op", {busy, done, div0, zhigh, zlow}, '0);
      start = 1'b1; a = 32'd2; b = 32'd3;
      @(posedge clk);
      @(negedge clk);
      clr = 1'b0; start = 1'b0;
      chk("clr_beats_start", 65'(busy), 65'(0));
      idle_check(45, "clr_no_done");
      {exp_d0, exp_hi, exp_lo} = '0;

      for (int i = 0; i < 40; i++) begin
         logic o;
         logic [W-1:0] x, y;
         o = 1'($urandom_range(0, 1));
         x = pick($urandom_range(0, 9));
         y = pick($urandom_range(0, 9));
         run_op(o, x, y, 0, o ? "rand_div" : "rand_mul");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
